// File: rtl/ram2video_pkg.sv
// Shared constants and types for the line-buffer read side (ram2video).
// Timing defaults, FSM state encoding and address widths shared with the capture side.
package ram2video_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CNT_W  = 12;
  localparam int ADDR_W = 15;
  localparam int LINE_W = 2;
  localparam int COL_W  = 10;
  localparam int RGB_W  = 24;

  localparam int BAR_WIDTH = 80;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Eight vertical bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram2video_timing.sv
// Raster generator for ram2video: IDLE/RUN FSM, X/Y counters and undelayed sync/de decode.
module ram2video_timing
  import ram2video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic starttrigger,
  output cnt_t x,
  output cnt_t y,
  output logic active,
  output logic hsync_n,
  output logic vsync_n,
  output logic locked
);

  localparam cnt_t X_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t Y_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t X_ACT    = cnt_t'(H_ACTIVE);
  localparam cnt_t Y_ACT    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  state_t state_q, state_d;
  cnt_t   x_q, x_d, y_q, y_d;
  logic   run;

  // Counters sit at 0,0 while idle so the first RUN cycle is pixel 0 of line 0.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (state_q == ST_IDLE) begin
      x_d = '0;
      y_d = '0;
      if (starttrigger) state_d = ST_RUN;
    end else if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + cnt_t'(1);
    end else begin
      x_d = x_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign run     = (state_q == ST_RUN);
  assign x       = x_q;
  assign y       = y_q;
  assign active  = run && (x_q < X_ACT) && (y_q < Y_ACT);
  assign hsync_n = !(run && (x_q >= HS_START) && (x_q < HS_END));
  assign vsync_n = !(run && (y_q >= VS_START) && (y_q < VS_END));
  assign locked  = run;

endmodule

// File: rtl/ram2video.sv
// Line-buffer read side: raster-driven RAM addressing, RAM-latency-matched sync/de pipeline, pixel output.
// Optional colour bars are built only when RAM2VIDEO_TESTPATTERN_EN is defined.
module ram2video
  import ram2video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              starttrigger,
  input  logic              line_doubler,
  input  logic              test_pattern,
  input  logic [RGB_W-1:0]  rddata,
  output logic [ADDR_W-1:0] rdaddr,
  output logic              rdclock,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              locked
);

  // Stage k of the pipeline lines up with the RAM output k cycles after rdaddr.
  localparam int PIPE = RAM_LATENCY + 1;

  cnt_t x, y;
  logic cnt_active, cnt_hsync_n, cnt_vsync_n;

  ram2video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock        (clock),
    .reset        (reset),
    .starttrigger (starttrigger),
    .x            (x),
    .y            (y),
    .active       (cnt_active),
    .hsync_n      (cnt_hsync_n),
    .vsync_n      (cnt_vsync_n),
    .locked       (locked)
  );

  logic                ld_q, ld_d;
  logic [LINE_W-1:0]   line_idx;
  logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;
  logic [PIPE-1:0]     de_pipe_q, de_pipe_d;
  logic [PIPE-1:0]     hs_pipe_q, hs_pipe_d;
  logic [PIPE-1:0]     vs_pipe_q, vs_pipe_d;
  logic [RGB_W-1:0]    pixel;
  logic [RGB_W-1:0]    rgb_q, rgb_d;
  logic                de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  // Doubler mode only changes at frame start so a frame never mixes line mappings.
  always_comb begin
    ld_d      = ((x == '0) && (y == '0)) ? line_doubler : ld_q;
    line_idx  = ld_q ? y[LINE_W:1] : y[LINE_W-1:0];
    rdaddr_d  = '0;
    if (cnt_active) rdaddr_d = {{(ADDR_W-LINE_W-COL_W){1'b0}}, line_idx, x[COL_W-1:0]};
    de_pipe_d = {de_pipe_q[PIPE-2:0], cnt_active};
    hs_pipe_d = {hs_pipe_q[PIPE-2:0], cnt_hsync_n};
    vs_pipe_d = {vs_pipe_q[PIPE-2:0], cnt_vsync_n};
  end

`ifdef RAM2VIDEO_TESTPATTERN_EN
  logic [2:0] bar_idx;
  logic [2:0] bar_pipe_q [PIPE];
  logic [2:0] bar_pipe_d [PIPE];

  always_comb begin
    bar_idx       = 3'(x[COL_W-1:0] / COL_W'(BAR_WIDTH));
    bar_pipe_d[0] = bar_idx;
    for (int i = 1; i < PIPE; i++) bar_pipe_d[i] = bar_pipe_q[i-1];
    pixel = test_pattern ? bar_colour(bar_pipe_q[PIPE-1]) : rddata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) bar_pipe_q[i] <= '0;
    end else begin
      bar_pipe_q <= bar_pipe_d;
    end
  end
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign pixel = rddata;
`endif

  always_comb begin
    de_d  = de_pipe_q[PIPE-1];
    hs_d  = hs_pipe_q[PIPE-1];
    vs_d  = vs_pipe_q[PIPE-1];
    rgb_d = de_pipe_q[PIPE-1] ? pixel : '0;
  end

  // Reset flushes the whole pipeline so no stale pixels leak out after a restart.
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_q      <= 1'b0;
      rdaddr_q  <= '0;
      de_pipe_q <= '0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      ld_q      <= ld_d;
      rdaddr_q  <= rdaddr_d;
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign rdaddr    = rdaddr_q;
  assign rdclock   = clock;
  assign {R, G, B} = rgb_q;
  assign de        = de_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;

endmodule

// File: tb/tb_ram2video.sv
// Self-checking bench for ram2video: cycle scoreboard against a raster model plus table-driven pixel vectors.
// Vertical timing is shortened so several frames fit in a short run; horizontal timing is the default 800.
module tb_ram2video;

  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int HT  = 800;
  localparam int OUT_LAT = 4;
  localparam int WAIT_LIMIT = 16000;

  logic        clock = 1'b0;
  logic        reset;
  logic        starttrigger;
  logic        line_doubler;
  logic        test_pattern;
  logic [23:0] rddata;
  logic [14:0] rdaddr;
  logic        rdclock;
  logic [7:0]  R, G, B;
  logic        hsync, vsync, de, locked;

  ram2video #(
    .V_ACTIVE    (VA),
    .V_FP        (VFP),
    .V_SYNC      (VS),
    .V_BP        (VBP),
    .RAM_LATENCY (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .starttrigger (starttrigger),
    .line_doubler (line_doubler),
    .test_pattern (test_pattern),
    .rddata       (rddata),
    .rdaddr       (rdaddr),
    .rdclock      (rdclock),
    .R            (R),
    .G            (G),
    .B            (B),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .locked       (locked)
  );

  always #5 clock = ~clock;

  // Buffer RAM model: two-cycle read latency, data equals address.
  logic [14:0] ram_d1, ram_d2;
  always @(posedge clock) begin
    ram_d1 <= rdaddr;
    ram_d2 <= ram_d1;
  end
  assign rddata = {9'd0, ram_d2};

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s t=%0t actual=%0h expected=%0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [23:0] barColour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Raster model, advanced on the same edges as the DUT counters.
  logic m_rst = 1'b1;
  logic m_run = 1'b0;
  logic m_ld  = 1'b0;
  int   mx = 0, my = 0;
  int   m_frame = -1;

  always @(posedge clock) begin
    m_rst <= reset;
    if (reset) begin
      m_run <= 1'b0;
      mx    <= 0;
      my    <= 0;
      m_ld  <= 1'b0;
    end else if (!m_run) begin
      mx <= 0;
      my <= 0;
      if (starttrigger) begin
        m_run   <= 1'b1;
        m_frame <= m_frame + 1;
      end
    end else begin
      if (mx == 0 && my == 0) m_ld <= line_doubler;
      if (mx == HT - 1) begin
        mx <= 0;
        if (my == VT - 1) begin
          my      <= 0;
          m_frame <= m_frame + 1;
        end else begin
          my <= my + 1;
        end
      end else begin
        mx <= mx + 1;
      end
    end
  end

  logic tp_model;
`ifdef RAM2VIDEO_TESTPATTERN_EN
  assign tp_model = test_pattern;
`else
  assign tp_model = 1'b0;
`endif

  typedef struct {
    logic [26:0] out;
    int          frame;
    int          y;
    int          x;
  } sb_t;

  localparam logic [26:0] IDLE_OUT = {1'b1 == 1'b0, 1'b1, 1'b1, 24'd0};

  sb_t         sb_q[$];
  sb_t         item;
  logic        sb_en = 1'b0;
  logic        e_de, e_hs, e_vs;
  int          e_line;
  logic [14:0] e_addr;
  logic [14:0] prev_addr = 15'd0;
  logic [23:0] e_rgb;
  int          out_frame = -2, out_y = -2, out_x = -2;

  // Scoreboard: push the expected output for the current counter position, pop it OUT_LAT cycles later.
  always @(negedge clock) begin
    if (sb_en) begin
      e_de   = m_run && mx < 640 && my < VA;
      e_hs   = !(m_run && mx >= 656 && mx < 752);
      e_vs   = !(m_run && my >= VA + VFP && my < VA + VFP + VS);
      e_line = (m_ld ? (my / 2) : my) % 4;
      e_addr = e_de ? 15'(e_line * 1024 + mx) : 15'd0;
      e_rgb  = e_de ? (tp_model ? barColour(mx / 80) : {9'd0, e_addr}) : 24'd0;
      checkOutput("rdaddr", 64'(rdaddr), m_rst ? 64'd0 : 64'(prev_addr));
      prev_addr = e_addr;
      checkOutput("locked", 64'(locked), 64'(m_run));
      if (m_rst) begin
        sb_q.delete();
        for (int i = 0; i < OUT_LAT; i++) sb_q.push_back('{out: IDLE_OUT, frame: -1, y: -1, x: -1});
      end
      sb_q.push_back('{out: {e_de, e_hs, e_vs, e_rgb}, frame: (m_run ? m_frame : -1), y: my, x: mx});
      if (sb_q.size() > OUT_LAT) begin
        item = sb_q.pop_front();
        checkOutput("sb_out", 64'({de, hsync, vsync, R, G, B}), 64'(item.out));
        out_frame = item.frame;
        out_y     = item.y;
        out_x     = item.x;
      end
    end
  end

  typedef struct {
    int          frame;
    int          y;
    int          x;
    logic        ld;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input int f, input int yy, input int xx, input logic ld,
                                 input logic [23:0] rgb, input logic d, input logic h, input logic v);
    vec_t r;
    r.frame = f; r.y = yy; r.x = xx; r.ld = ld; r.rgb = rgb; r.de = d; r.hs = h; r.vs = v;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    line_doubler = v.ld;
  endtask

  task automatic waitOutput(input int f, input int yy, input int xx, output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < WAIT_LIMIT) begin
      @(negedge clock);
      #1;
      ok = (out_frame == f && out_y == yy && out_x == xx);
      n++;
    end
    if (!ok) begin
      failures++;
      checks++;
      $display("[TB] FAIL wait_output frame=%0d y=%0d x=%0d timed out", f, yy, xx);
    end
  endtask

  task automatic waitCounter(input int f, input int yy, input int xx, output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < WAIT_LIMIT) begin
      @(negedge clock);
      #1;
      ok = (m_run && m_frame == f && my == yy && mx == xx);
      n++;
    end
    if (!ok) begin
      failures++;
      checks++;
      $display("[TB] FAIL wait_counter frame=%0d y=%0d x=%0d timed out", f, yy, xx);
    end
  endtask

  task automatic applyTrigger();
    @(negedge clock);
    starttrigger = 1'b1;
    @(posedge clock);
    #1;
    starttrigger = 1'b0;
    checkOutput("locked_after_trigger", 64'(locked), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      checkOutput("first_de_timing", 64'(de), (k == 4) ? 64'd1 : 64'd0);
      if (k >= 2) checkOutput("restart_rdaddr", 64'(rdaddr), 64'(k - 1));
    end
  endtask

  localparam logic [23:0] F2_85  = 24'h000055;
  localparam logic [23:0] F2_639 = 24'h00027F;
  localparam logic [23:0] F2_510 = 24'h00040A;
`ifdef RAM2VIDEO_TESTPATTERN_EN
  localparam logic [23:0] TP_85  = 24'hFFFF00;
  localparam logic [23:0] TP_639 = 24'h000000;
  localparam logic [23:0] TP_510 = 24'hFFFFFF;
`else
  localparam logic [23:0] TP_85  = F2_85;
  localparam logic [23:0] TP_639 = F2_639;
  localparam logic [23:0] TP_510 = F2_510;
`endif

  initial begin
    logic ok;
    logic restarted;
    reset        = 1'b1;
    starttrigger = 1'b0;
    line_doubler = 1'b0;
    test_pattern = 1'b0;
    restarted    = 1'b0;

    vecs.push_back(mkVec(0,  0,   0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(0,  0, 639, 1'b0, 24'h00027F, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(0,  0, 640, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mkVec(0,  0, 656, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkVec(0,  0, 751, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkVec(0,  0, 752, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mkVec(0,  5,  10, 1'b0, 24'h00040A, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(0,  6,  10, 1'b0, 24'h00080A, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(0,  7,  10, 1'b0, 24'h000C0A, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(0, 10,  10, 1'b1, 24'h00080A, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(0, 13,   0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mkVec(0, 14,   0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkVec(0, 15, 700, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(0, 16,   0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mkVec(1,  5,  10, 1'b1, 24'h00080A, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(1,  6,  10, 1'b1, 24'h000C0A, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(1,  7,  10, 1'b1, 24'h000C0A, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(1,  9, 639, 1'b1, 24'h00027F, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(2,  0,  85, 1'b0, TP_85,      1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(2,  0, 639, 1'b0, TP_639,     1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(2,  0, 700, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkVec(2,  5,  10, 1'b0, TP_510,     1'b1, 1'b1, 1'b1));

    repeat (2) @(posedge clock);
    #1;
    sb_en = 1'b1;
    repeat (8) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #1;
      checkOutput("idle_outputs", {rdaddr, de, hsync, vsync, locked, R, G, B},
                  {15'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0});
    end

    applyTrigger();

    ok = 1'b1;
    for (int i = 0; i < vecs.size() && ok; i++) begin
      if (vecs[i].frame == 2 && !restarted) begin
        restarted = 1'b1;
        waitCounter(1, 10, 300, ok);
        if (ok) begin
          reset = 1'b1;
          @(posedge clock);
          #1;
          checkOutput("midframe_reset", {rdaddr, de, hsync, vsync, locked, R, G, B},
                      {15'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0});
          @(negedge clock);
          starttrigger = 1'b1;
          @(posedge clock);
          #1;
          starttrigger = 1'b0;
          checkOutput("reset_beats_trigger", 64'(locked), 64'd0);
          @(negedge clock);
          reset        = 1'b0;
          line_doubler = 1'b0;
          test_pattern = 1'b1;
          repeat (5) @(posedge clock);
          #1;
          checkOutput("trigger_lost", 64'(locked), 64'd0);
          applyTrigger();
        end
      end
      if (ok) begin
        applyStimulus(vecs[i]);
        waitOutput(vecs[i].frame, vecs[i].y, vecs[i].x, ok);
        if (ok)
          checkOutput($sformatf("vec%0d", i), 64'({de, hsync, vsync, R, G, B}),
                      64'({vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].rgb}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
